// File: rtl/mult_rr_sched_if.sv
// Start/valid handshake between the scheduler and the shared multiplier.
// master = scheduler (operands, start), slave = multiplier (valid, product).
interface mult_rr_sched_if #(
  parameter int W = 5
);
  logic [W-1:0]   omul_a;
  logic [W-1:0]   omul_b;
  logic           omul_start;
  logic           imul_valid;
  logic [2*W-1:0] imul_res;

  modport master (
    output omul_a, omul_b, omul_start,
    input  imul_valid, imul_res
  );

  modport slave (
    input  omul_a, omul_b, omul_start,
    output imul_valid, imul_res
  );
endinterface

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: round-robin share of one WxW multiplier among NREQ clients.
// Ports: iclk/irst_n (sync, active low); ireq/ia/ib requester side;
//   ogrant/ovalid one-hot pulses, ores product, obusy; mul = multiplier
//   handshake (omul_a/omul_b/omul_start out, imul_valid/imul_res in).
// Optional MULT_RR_SCHED_TIMEOUT_EN: WAIT timeout (TMO) with oerr output.
module mult_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 5
`ifdef MULT_RR_SCHED_TIMEOUT_EN
  ,
  parameter int TMO  = 15
`endif
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic [NREQ-1:0]     ireq,
  input  logic [NREQ*W-1:0]   ia,
  input  logic [NREQ*W-1:0]   ib,
  output logic [NREQ-1:0]     ogrant,
  output logic [2*W-1:0]      ores,
  output logic [NREQ-1:0]     ovalid,
  output logic                obusy,
`ifdef MULT_RR_SCHED_TIMEOUT_EN
  output logic                oerr,
`endif
  mult_rr_sched_if.master     mul
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_last;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_sel;
  logic           w_any;
  logic           w_take;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_res;
  logic           w_tmo;
`ifdef MULT_RR_SCHED_TIMEOUT_EN
  logic [3:0]     r_cnt;
  logic           r_tmo;
`endif

  // Search last+1, last+2, ... so the requester just served ranks last.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_any && ireq[(int'(r_last) + i) % NREQ]) begin
        w_any = 1'b1;
        w_sel = IW'((int'(r_last) + i) % NREQ);
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_any;

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE:    if (w_any) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (mul.imul_valid) begin
          w_next = S_CAPTURE;
        end
`ifdef MULT_RR_SCHED_TIMEOUT_EN
        else if (r_cnt == 4'(TMO - 1)) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
`endif
      end
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NREQ - 1);
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_idx  <= w_sel;
        r_last <= w_sel;
        r_a    <= ia[w_sel*W +: W];
        r_b    <= ib[w_sel*W +: W];
      end
      // Product is only guaranteed on the cycle after imul_valid.
      if (r_state == S_CAPTURE) r_res <= mul.imul_res;
      if (w_tmo) r_res <= '0;
    end
  end

`ifdef MULT_RR_SCHED_TIMEOUT_EN
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
      r_tmo <= w_tmo;
    end
  end

  assign oerr = r_tmo;
`endif

  // Grant is combinational in IDLE; masked while reset is being applied.
  assign ogrant = (w_take && irst_n) ? (NREQ'(1) << w_sel) : '0;
  assign ovalid = (r_state == S_DONE) ? (NREQ'(1) << r_idx) : '0;
  assign ores   = r_res;
  assign obusy  = (r_state != S_IDLE);

  assign mul.omul_a     = r_a;
  assign mul.omul_b     = r_b;
  assign mul.omul_start = (r_state == S_ISSUE);

endmodule

// File: tb/tb_mult_rr_sched.sv
// Scoreboard bench for mult_rr_sched with a behavioural multiplier.
// Grants/results are predicted from round-robin rules and plain products.
module tb_mult_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 5;
`ifdef MULT_RR_SCHED_TIMEOUT_EN
  localparam int TMO  = 15;
`endif

  logic              iclk = 1'b0;
  logic              irst_n;
  logic [NREQ-1:0]   ireq;
  logic [NREQ*W-1:0] ia;
  logic [NREQ*W-1:0] ib;
  logic [NREQ-1:0]   ogrant;
  logic [2*W-1:0]    ores;
  logic [NREQ-1:0]   ovalid;
  logic              obusy;
`ifdef MULT_RR_SCHED_TIMEOUT_EN
  logic              oerr;
`endif

  logic           mv;
  logic           sv;
  logic [2*W-1:0] mres;

  mult_rr_sched_if #(.W(W)) mif ();
  assign mif.imul_valid = mv | sv;
  assign mif.imul_res   = mres;

  mult_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .ireq   (ireq),
    .ia     (ia),
    .ib     (ib),
    .ogrant (ogrant),
    .ores   (ores),
    .ovalid (ovalid),
    .obusy  (obusy),
`ifdef MULT_RR_SCHED_TIMEOUT_EN
    .oerr   (oerr),
`endif
    .mul    (mif)
  );

  always #5 iclk = ~iclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Priority = distance after last serviced index, smallest wins.
  function automatic logic [NREQ-1:0] ref_grant(
      input logic [NREQ-1:0] req, input int last);
    int best;
    int bd;
    best = -1;
    bd   = NREQ + 1;
    for (int k = 0; k < NREQ; k++) begin
      if (req[k]) begin
        int d;
        d = (k - last - 1 + 2 * NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = k;
        end
      end
    end
    return (best < 0) ? '0 : (NREQ'(1) << best);
  endfunction

  // Behavioural multiplier: valid L cycles after start, product held after.
  int lat      = 1;
  bit rand_lat = 0;
  bit mute     = 0;
  int st_cyc   = 0;
  int st_lat   = 1;

  initial begin
    mv   = 1'b0;
    mres = '0;
    forever begin
      @(posedge iclk);
      #1;
      if (mif.omul_start && !mute) begin
        int L;
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = mif.omul_a;
        b = mif.omul_b;
        L = rand_lat ? int'($urandom_range(1, 4)) : lat;
        st_cyc = cyc;
        st_lat = L;
        repeat (L - 1) @(posedge iclk);
        @(posedge iclk);
        #1;
        mv   = 1'b1;
        mres = (2*W)'(a) * (2*W)'(b);
        @(posedge iclk);
        #1;
        mv = 1'b0;
      end else if (mif.omul_start) begin
        st_cyc = cyc;
        st_lat = 0;
      end
    end
  end

  typedef struct {
    int idx;
    int prod;
    bit err;
  } exp_t;

  exp_t            q[$];
  int              grant_log[$];
  int              gcyc_log[$];
  bit              busy     = 0;
  int              mlast    = NREQ - 1;
  int              busy_cyc = 0;
  logic [W-1:0]    g_a;
  logic [W-1:0]    g_b;
  logic [NREQ-1:0] gmask    = '0;
  int              lv_cyc   = 0;
  int              lv_res   = 0;

  // Monitor: predicts grants from ireq, pops the scoreboard on ovalid.
  always @(negedge iclk) begin
    gmask = '0;
    if (!irst_n) begin
      q.delete();
      busy  = 0;
      mlast = NREQ - 1;
    end else begin
      logic [NREQ-1:0] em;
      chk("obusy", obusy, busy);
      if (!busy) begin
        em = ref_grant(ireq, mlast);
        chk("grant", ogrant, em);
        if (em != '0) begin
          exp_t e;
          for (int k = 0; k < NREQ; k++) if (em[k]) e.idx = k;
          g_a    = ia[e.idx*W +: W];
          g_b    = ib[e.idx*W +: W];
          e.prod = int'(g_a) * int'(g_b);
          e.err  = mute;
          if (mute) e.prod = 0;
          q.push_back(e);
          mlast    = e.idx;
          busy     = 1;
          busy_cyc = cyc;
          gmask    = em;
          grant_log.push_back(e.idx);
          gcyc_log.push_back(cyc);
        end
      end else begin
        chk("grant_while_busy", ogrant, 0);
      end
      if (mif.omul_start) begin
        chk("start_cyc", cyc, busy_cyc + 1);
        chk("start_a", mif.omul_a, g_a);
        chk("start_b", mif.omul_b, g_b);
      end
      if (ovalid != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", ovalid, 0);
        end else begin
          exp_t e;
          int   dc;
          e = q.pop_front();
          chk("valid_idx", ovalid, NREQ'(1) << e.idx);
          chk("ores", ores, e.prod);
          dc = st_cyc + 2 + st_lat;
`ifdef MULT_RR_SCHED_TIMEOUT_EN
          if (e.err) dc = st_cyc + 1 + TMO;
          chk("oerr", oerr, e.err);
`endif
          chk("done_cyc", cyc, dc);
          lv_cyc = cyc;
          lv_res = int'(ores);
          busy   = 0;
        end
      end
`ifdef MULT_RR_SCHED_TIMEOUT_EN
      else if (oerr) begin
        chk("oerr_stray", oerr, 0);
      end
`endif
      if (busy && (cyc - busy_cyc > 60)) begin
        chk("busy_timeout", cyc - busy_cyc, 0);
        busy = 0;
        q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #2;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    ia[k*W +: W] = W'(a);
    ib[k*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    chk("rst_ogrant", ogrant, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_ores", ores, 0);
    chk("rst_obusy", obusy, 0);
    chk("rst_mul_a", mif.omul_a, 0);
    chk("rst_mul_b", mif.omul_b, 0);
    chk("rst_start", mif.omul_start, 0);
    #1;
    irst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grants(input int n0, input int need);
    int t;
    t = 0;
    while (grant_log.size() < n0 + need && t < 100) begin
      tick();
      t++;
    end
    if (grant_log.size() < n0 + need)
      chk("grant_timeout", grant_log.size(), n0 + need);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || q.size() != 0 || mv) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("idle_timeout", t, 0);
    tick();
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    int n0;
    int order[5];
    order  = '{0, 1, 2, 3, 0};
    irst_n = 1'b0;
    ireq   = '0;
    ia     = '0;
    ib     = '0;
    sv     = 1'b0;
    tick();
    do_reset();

    // Single request: 3*7, latency grant -> ovalid of 4.
    n0 = grant_log.size();
    set_op(0, 3, 7);
    ireq = 4'b0001;
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    if (grant_log.size() > n0) begin
      chk("t1_idx", grant_log[n0], 0);
      chk("t1_lat", lv_cyc - gcyc_log[n0], 4);
    end
    chk("t1_res", lv_res, 21);

    // All four requesting continuously from reset.
    do_reset();
    n0 = grant_log.size();
    for (int k = 0; k < NREQ; k++) set_op(k, k + 1, 10);
    ireq = 4'b1111;
    wait_grants(n0, 5);
    ireq = '0;
    wait_idle();
    if (grant_log.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++)
        chk("t2_order", grant_log[n0+i], order[i]);
      for (int i = 1; i < 5; i++)
        chk("t2_spacing", gcyc_log[n0+i] - gcyc_log[n0+i-1], 5);
    end

    // Fairness with last=2 and ireq=1011.
    do_reset();
    n0 = grant_log.size();
    set_op(2, 4, 4);
    ireq = 4'b0100;
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    n0 = grant_log.size();
    set_op(0, 1, 2);
    set_op(1, 6, 5);
    set_op(3, 9, 3);
    ireq = 4'b1011;
    wait_grants(n0, 3);
    ireq = '0;
    wait_idle();
    if (grant_log.size() >= n0 + 3) begin
      chk("t3_g0", grant_log[n0], 3);
      chk("t3_g1", grant_log[n0+1], 0);
      chk("t3_g2", grant_log[n0+2], 1);
    end

    // Extremes, then a stray valid while idle.
    set_op(0, 31, 31);
    ireq = 4'b0001;
    n0 = grant_log.size();
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    chk("max_res", lv_res, 961);
    set_op(1, 0, 25);
    ireq = 4'b0010;
    n0 = grant_log.size();
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    chk("zero_res", lv_res, 0);
    sv = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    @(negedge iclk);
    chk("stray_busy", obusy, 0);
    chk("stray_ores", ores, 0);
    tick();

    // Reset while waiting on a slow multiplier; late valid is ignored.
    lat = 4;
    set_op(0, 5, 5);
    ireq = 4'b0001;
    n0 = grant_log.size();
    wait_grants(n0, 1);
    ireq = '0;
    tick();
    do_reset();
    repeat (8) tick();
    wait_idle();
    lat = 1;
    set_op(2, 7, 3);
    ireq = 4'b0100;
    n0 = grant_log.size();
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    if (grant_log.size() > n0) chk("t5_grant", grant_log[n0], 2);
    chk("t5_res", lv_res, 21);

    // Randomised traffic with random multiplier latency.
    rand_lat = 1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (ireq[k]) begin
          if (gmask[k]) begin
            if ($urandom_range(0, 1) == 0) ireq[k] = 1'b0;
            else set_op(k, int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_op(k, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)));
          ireq[k] = 1'b1;
        end
      end
      tick();
    end
    ireq = '0;
    wait_idle();
    rand_lat = 0;

`ifdef MULT_RR_SCHED_TIMEOUT_EN
    mute = 1;
    set_op(0, 9, 9);
    ireq = 4'b0001;
    n0 = grant_log.size();
    wait_grants(n0, 1);
    ireq = '0;
    wait_idle();
    mute = 0;
    if (grant_log.size() > n0)
      chk("tmo_lat", lv_cyc - gcyc_log[n0], TMO + 2);
    chk("tmo_res", lv_res, 0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
